// File: rtl/rand_tile_pkg.sv
// Shared state encoding, grid geometry and payload types for the random tile consumer.
package rand_tile_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_PRESENT = PRESENT,
    ST_HOLD    = HOLD
  } tile_state_t;

  localparam int unsigned GRID_DIM = 4;
  localparam int unsigned COORD_W  = $clog2(GRID_DIM);
  localparam int unsigned RAND_W   = 2 * COORD_W;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned NANOS_W  = 28;
  localparam int unsigned HOLD_W   = 8;

  // A random value split into grid coordinates: row in the upper bits, column in the lower.
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } tile_pos_t;

endpackage

// File: rtl/rand_tile_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head entry whenever the FIFO is non-empty.
module rand_tile_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rand_tile_consumer.sv
// Samples the random generator once per period, queues the values and presents each as a held grid tile.
// Build macro RAND_TILE_DEDUP_EN drops samples equal to the last pushed value.
module rand_tile_consumer
  import rand_tile_pkg::*;
#(
  parameter int unsigned SAMPLE_OFFSET = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HOLD_FRAMES   = 30
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [RAND_W-1:0]   rand_in,
  input  logic [NANOS_W-1:0]  nanos_in,
  input  logic                frame_tick,
  input  logic                tile_ready,
  output logic                tile_valid,
  output logic [COORD_W-1:0]  tile_x,
  output logic [COORD_W-1:0]  tile_y,
  output logic [COLOR_W-1:0]  tile_color,
  output logic                tile_active,
  output logic [4:0]          fifo_count,
  output logic                overflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tile_state_t         state_q;
  tile_state_t         state_next;
  logic [RAND_W-1:0]   sample_q;
  logic                sample_pend_q;
  logic                push_req_c;
  logic                push_ok_c;
  logic                pop_c;
  logic [RAND_W-1:0]   fifo_head;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_next;
  logic [COLOR_W-1:0]  color_q;
  logic [COLOR_W-1:0]  color_next;
  tile_pos_t           head_pos;

  assign head_pos   = tile_pos_t'(fifo_head);
  assign fifo_count = 5'(fifo_cnt);
  assign push_ok_c  = ~fifo_full | pop_c;

  // Strobe: register the value in the cycle the period counter hits the offset; push it the next cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sample_pend_q <= 1'b0;
      sample_q      <= '0;
    end else begin
      sample_pend_q <= (nanos_in == NANOS_W'(SAMPLE_OFFSET));
      if (nanos_in == NANOS_W'(SAMPLE_OFFSET)) sample_q <= rand_in;
    end
  end

`ifdef RAND_TILE_DEDUP_EN
  logic [RAND_W-1:0] last_q;

  assign push_req_c = sample_pend_q & (sample_q != last_q);

  always_ff @(posedge CLK) begin
    if (reset)                       last_q <= 4'hF;
    else if (push_req_c & push_ok_c) last_q <= sample_q;
  end
`else
  assign push_req_c = sample_pend_q;
`endif

  rand_tile_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RAND_W)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push_req_c),
    .pop   (pop_c),
    .din   (sample_q),
    .dout  (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_next;
      hold_q  <= hold_next;
      color_q <= color_next;
    end
  end

  // A frame_tick during acceptance is ignored because the hold count only runs in HOLD.
  always_comb begin
    state_next = state_q;
    hold_next  = hold_q;
    color_next = color_q;
    pop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (tile_ready) begin
          pop_c      = 1'b1;
          color_next = color_q + 1'b1;
          hold_next  = HOLD_W'(HOLD_FRAMES);
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          hold_next = hold_q - 1'b1;
          if (hold_q == HOLD_W'(1)) state_next = fifo_empty ? ST_IDLE : ST_PRESENT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Tile fields are captured from the FIFO head on entry to PRESENT and held until the next entry.
  always_ff @(posedge CLK) begin
    if (reset) begin
      tile_valid  <= 1'b0;
      tile_active <= 1'b0;
      tile_x      <= '0;
      tile_y      <= '0;
      tile_color  <= '0;
      overflow    <= 1'b0;
    end else begin
      tile_valid  <= (state_next == ST_PRESENT);
      tile_active <= (state_next == ST_HOLD);
      if (state_next == ST_PRESENT && state_q != ST_PRESENT) begin
        tile_x     <= head_pos.x;
        tile_y     <= head_pos.y;
        tile_color <= color_next;
      end
      if (push_req_c && !push_ok_c) overflow <= 1'b1;
    end
  end

endmodule
